// File: rtl/cfu_initiator.sv
// cfu_initiator: single-outstanding core-side initiator for the CFU cmd/rsp protocol, with flush and timeout recovery.
// Latency: request accepted in cycle 0 -> cmd_valid in cycle 1 -> core_rsp_valid in cycle 3 with a zero-wait CFU.
// Backpressure: core_req_ready low while busy or stale; cmd held stable until cmd_ready; core response has no back-pressure.
// Optional feature: define CFU_PERF_CNT_EN to build the perf_ops / perf_stall counters (ports read 0 otherwise).
module cfu_initiator #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    // core request
    input  logic        core_req_valid,
    output logic        core_req_ready,
    input  logic [6:0]  core_funct7,
    input  logic [2:0]  core_funct3,
    input  logic [31:0] core_rs1,
    input  logic [31:0] core_rs2,
    input  logic [4:0]  core_rd_addr,
    input  logic        core_flush,
    // core response
    output logic        core_rsp_valid,
    output logic [31:0] core_rsp_data,
    output logic [4:0]  core_rsp_rd_addr,
    output logic        core_rsp_error,
    output logic        busy,
    // CFU command channel
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [9:0]  cmd_payload_function_id,
    output logic [31:0] cmd_payload_inputs_0,
    output logic [31:0] cmd_payload_inputs_1,
    // CFU response channel
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [31:0] rsp_payload_outputs_0,
    // performance counters
    output logic [31:0] perf_ops,
    output logic [31:0] perf_stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // A zero TIMEOUT_CYCLES disables the timeout; the compare value is then unused.
    localparam bit              TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t             state_q, state_d;
    logic [9:0]         fid_q, fid_d;
    logic [31:0]        in0_q, in0_d;
    logic [31:0]        in1_q, in1_d;
    logic [4:0]         rd_q, rd_d;
    logic [31:0]        data_q, data_d;
    logic               err_q, err_d;
    logic               killed_q, killed_d;
    logic               stale_q, stale_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_hit;

    assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

    // Next-state and handshake outputs; every target gets its hold/idle default first.
    always_comb begin
        state_d        = state_q;
        fid_d          = fid_q;
        in0_d          = in0_q;
        in1_d          = in1_q;
        rd_d           = rd_q;
        data_d         = data_q;
        err_d          = err_q;
        killed_d       = killed_q;
        stale_d        = stale_q;
        cnt_d          = cnt_q;
        cmd_valid      = 1'b0;
        rsp_ready      = stale_q;
        core_req_ready = 1'b0;
        core_rsp_valid = 1'b0;

        // A response owed by a timed-out command is swallowed here, whatever the FSM is doing.
        if (stale_q && rsp_valid) begin
            stale_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // stale_q is registered, so a request can never be taken in the cycle stale clears.
                core_req_ready = !stale_q;
                if (core_req_valid && !stale_q) begin
                    fid_d    = {core_funct7, core_funct3};
                    in0_d    = core_rs1;
                    in1_d    = core_rs2;
                    rd_d     = core_rd_addr;
                    cnt_d    = '0;
                    killed_d = 1'b0;
                    state_d  = S_CMD;
                end
            end
            S_CMD: begin
                // cmd_valid stays up through a flush; only the timeout may withdraw it.
                cmd_valid = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (core_flush) begin
                    killed_d = 1'b1;
                end
                if (cmd_ready) begin
                    state_d = S_WAIT;
                end else if (timeout_hit) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                rsp_ready = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (core_flush) begin
                    killed_d = 1'b1;
                end
                if (rsp_valid) begin
                    data_d  = rsp_payload_outputs_0;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    // The CFU still owes a response; remember to discard it.
                    data_d  = '0;
                    err_d   = 1'b1;
                    stale_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                core_rsp_valid = !killed_q;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight command and any pending stale response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            fid_q    <= '0;
            in0_q    <= '0;
            in1_q    <= '0;
            rd_q     <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            killed_q <= 1'b0;
            stale_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            fid_q    <= fid_d;
            in0_q    <= in0_d;
            in1_q    <= in1_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            err_q    <= err_d;
            killed_q <= killed_d;
            stale_q  <= stale_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cmd_payload_function_id = fid_q;
    assign cmd_payload_inputs_0    = in0_q;
    assign cmd_payload_inputs_1    = in1_q;
    assign core_rsp_data           = data_q;
    assign core_rsp_rd_addr        = rd_q;
    assign core_rsp_error          = err_q & core_rsp_valid;
    assign busy                    = (state_q != S_IDLE) || stale_q;

`ifdef CFU_PERF_CNT_EN
    logic [31:0] perf_ops_q;
    logic [31:0] perf_stall_q;

    // Free-running wrap-around counters of delivered results and busy cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (core_rsp_valid) begin
                perf_ops_q <= perf_ops_q + 32'd1;
            end
            if (busy) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`else
    assign perf_ops   = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_cfu_initiator.sv
// tb_cfu_initiator: directed and randomized transactions against a per-transaction timing model of cfu_initiator.
// Latency: each transaction's expected cycle of every event is computed up front from its CFU delays.
// Backpressure: the bench plays the CFU, holding cmd_ready / rsp_valid off for the chosen delays.
`timescale 1ns/1ps
module tb_cfu_initiator;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req_valid;
    logic        core_req_ready;
    logic [6:0]  core_funct7;
    logic [2:0]  core_funct3;
    logic [31:0] core_rs1;
    logic [31:0] core_rs2;
    logic [4:0]  core_rd_addr;
    logic        core_flush;
    logic        core_rsp_valid;
    logic [31:0] core_rsp_data;
    logic [4:0]  core_rsp_rd_addr;
    logic        core_rsp_error;
    logic        busy;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;
    logic [31:0] perf_ops;
    logic [31:0] perf_stall;

    always #5 clk = ~clk;

    cfu_initiator #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .core_req_valid          (core_req_valid),
        .core_req_ready          (core_req_ready),
        .core_funct7             (core_funct7),
        .core_funct3             (core_funct3),
        .core_rs1                (core_rs1),
        .core_rs2                (core_rs2),
        .core_rd_addr            (core_rd_addr),
        .core_flush              (core_flush),
        .core_rsp_valid          (core_rsp_valid),
        .core_rsp_data           (core_rsp_data),
        .core_rsp_rd_addr        (core_rsp_rd_addr),
        .core_rsp_error          (core_rsp_error),
        .busy                    (busy),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .perf_ops                (perf_ops),
        .perf_stall              (perf_stall)
    );

    int          n_total = 0;
    int          n_pass  = 0;
    int unsigned model_ops  = 0;
    int unsigned model_busy = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Control outputs packed as {cmd_valid, rsp_ready, core_rsp_valid, busy, core_req_ready}.
    function automatic logic [4:0] ctl();
        return {cmd_valid, rsp_ready, core_rsp_valid, busy, core_req_ready};
    endfunction

    // One transaction. d1: cycles cmd_ready is held low; d2: cycles between cmd handshake and rsp_valid;
    // fl: cycle (relative to acceptance at 0) where core_flush pulses, -1 for none;
    // e: extra idle cycles before a late (stale) response is presented.
    task automatic run_op(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int d1, input int d2,
                          input int fl, input int e, input logic [31:0] res);
        bit          hs, ok, stale, killed;
        int          cmd_end, rsp_cyc, done;
        logic [4:0]  ectl;
        logic [31:0] edata;
        // The timeout fires on the TO-th CMD/WAIT cycle unless a handshake happens on that very cycle.
        hs      = (d1 <= TO - 1);
        ok      = hs && (d1 + 1 + d2 <= TO - 1);
        stale   = hs && !ok;
        cmd_end = hs ? 1 + d1 : TO;
        rsp_cyc = 2 + d1 + d2;
        done    = ok ? rsp_cyc + 1 : 1 + TO;
        killed  = (fl >= 1) && (fl <= done - 1);
        edata   = ok ? res : 32'h0;

        // cycle 0: idle, present the request
        check("idle_before_req", ctl(), 5'b00001);
        core_req_valid = 1'b1;
        core_funct7 = f7; core_funct3 = f3; core_rs1 = a; core_rs2 = b; core_rd_addr = rd;
        core_flush = (fl == 0);
        cmd_ready = 1'b0; rsp_valid = 1'b0;

        for (int c = 1; c <= done; c++) begin
            @(negedge clk);
            ectl[4] = (c <= cmd_end);
            ectl[3] = (hs && c > cmd_end && c < done) || (stale && c == done);
            ectl[2] = (c == done) && !killed;
            ectl[1] = 1'b1;
            ectl[0] = 1'b0;
            check($sformatf("ctl c%0d", c), ctl(), ectl);
            if (c <= cmd_end)
                check($sformatf("payload c%0d", c),
                      {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1}, {f7, f3, a, b});
            if (c == done && !killed)
                check("result", {core_rsp_data, core_rsp_rd_addr, core_rsp_error}, {edata, rd, !ok});
            // drive this cycle: scrambled core inputs prove the command was registered
            core_req_valid = 1'b0;
            core_funct7 = 7'($urandom); core_funct3 = 3'($urandom);
            core_rs1 = $urandom; core_rs2 = $urandom; core_rd_addr = 5'($urandom);
            core_flush = (c == fl);
            cmd_ready  = (hs && c == 1 + d1) || (c > cmd_end && ($urandom_range(0, 1) == 1));
            rsp_valid  = (ok && c == rsp_cyc) || (c <= cmd_end && ($urandom_range(0, 1) == 1));
            rsp_payload_outputs_0 = (c == rsp_cyc) ? res : $urandom;
        end

        for (int k = 0; k <= e; k++) begin
            @(negedge clk);
            check($sformatf("post ctl k%0d", k), ctl(), {1'b0, stale, 1'b0, stale, !stale});
            // during stale, a pending request must not be accepted, even in the clearing cycle
            core_req_valid = stale;
            core_flush = 1'b0; cmd_ready = 1'b0;
            rsp_valid = stale && (k == e);
            rsp_payload_outputs_0 = 32'hABCD;
        end
        @(negedge clk);
        check("back_to_idle", ctl(), 5'b00001);
        if (stale) check("stale_discarded", core_rsp_data, 32'h0);
        core_req_valid = 1'b0; rsp_valid = 1'b0;

        if (!killed) model_ops++;
        model_busy += done + (stale ? e + 1 : 0);
    endtask

    initial begin
        int d1, d2, fl;
        reset = 1'b1;
        core_req_valid = 1'b0; core_funct7 = '0; core_funct3 = '0; core_rs1 = '0; core_rs2 = '0;
        core_rd_addr = '0; core_flush = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0;
        rsp_payload_outputs_0 = '0;
        #12;
        check("reset ctl", ctl(), 5'b00001);
        check("reset data", {core_rsp_data, core_rsp_rd_addr, core_rsp_error, cmd_payload_function_id,
                             cmd_payload_inputs_0, cmd_payload_inputs_1}, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset asserted while waiting for the CFU response
        core_req_valid = 1'b1; core_funct7 = 7'h15; core_funct3 = 3'h2;
        core_rs1 = 32'h1111; core_rs2 = 32'h2222; core_rd_addr = 5'd9;
        @(negedge clk);
        core_req_valid = 1'b0; cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("rst_test wait", ctl(), 5'b01010);
        #2 reset = 1'b1;
        #1;
        check("async reset ctl", ctl(), 5'b00001);
        check("async reset data", {core_rsp_data, core_rsp_rd_addr, core_rsp_error, cmd_payload_function_id,
                                   cmd_payload_inputs_0, cmd_payload_inputs_1}, '0);
        check("async reset perf", {perf_ops, perf_stall}, '0);
        @(negedge clk);
        reset = 1'b0;
        rsp_valid = 1'b1; rsp_payload_outputs_0 = 32'hDEAD;
        check("late rsp not accepted", ctl(), 5'b00001);
        @(negedge clk);
        rsp_valid = 1'b0;
        check("late rsp ignored ctl", ctl(), 5'b00001);
        check("late rsp ignored data", core_rsp_data, 32'h0);

        // directed transactions
        run_op(7'h00, 3'h1, 32'h01010101, 32'h02020202, 5'd5, 0, 0, -1, 0, 32'h03030303);
        run_op(7'h2A, 3'h5, 32'hCAFEBABE, 32'h12345678, 5'd17, 10, 4, -1, 0, 32'h55AA55AA);
        run_op(7'h01, 3'h0, 32'h1, 32'h2, 5'd3, 0, 2, 3, 0, 32'h77);                 // flush in WAIT
        run_op(7'h01, 3'h0, 32'h3, 32'h4, 5'd4, 0, 0, 0, 0, 32'h88);                 // flush in IDLE
        run_op(7'h01, 3'h0, 32'h5, 32'h6, 5'd6, 0, 0, 3, 0, 32'h99);                 // flush in DONE
        run_op(7'h03, 3'h7, 32'h7, 32'h8, 5'd7, 0, 1, 3, 0, 32'hAA);                 // flush with rsp handshake
        run_op(7'h7F, 3'h7, 32'hFFFFFFFF, 32'h0, 5'd31, 0, TO, -1, 2, 32'hBB);       // timeout in WAIT
        run_op(7'h10, 3'h2, 32'h9, 32'hA, 5'd1, TO + 2, 0, -1, 0, 32'hCC);           // timeout in CMD
        run_op(7'h11, 3'h3, 32'hB, 32'hC, 5'd2, 0, TO - 2, -1, 0, 32'hDD);           // rsp on last cycle
        run_op(7'h12, 3'h4, 32'hD, 32'hE, 5'd8, 0, TO - 1, -1, 0, 32'hEE);           // one cycle too late
        run_op(7'h13, 3'h6, 32'hF, 32'h10, 5'd10, 0, TO, 5, 1, 32'hFF);              // killed timeout

        // randomized transactions
        for (int n = 0; n < 40; n++) begin
            d1 = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(0, TO + 3);
            if (d1 == TO - 1) d1 = TO;
            d2 = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 4) : $urandom_range(0, TO);
            fl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1;
            run_op(7'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom),
                   d1, d2, fl, $urandom_range(0, 3), $urandom);
        end

`ifdef CFU_PERF_CNT_EN
        check("perf_ops", perf_ops, model_ops);
        check("perf_stall", perf_stall, model_busy);
`else
        check("perf tied off", {perf_ops, perf_stall}, '0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cfu_initiator.md
Name: cfu_initiator

Overview:
- Core-side initiator for the custom function unit (CFU) command/response protocol.
- Accepts one custom-instruction request at a time from the Ibex execute stage and drives the CFU cmd channel.
- Collects the CFU response and returns the result to the core with an rd tag.
- Provides kill (flush) and timeout recovery; no outstanding-request pipelining.

Parameters:
- TIMEOUT_CYCLES, 255, cycles spent in CMD+WAIT before an error completion; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- core_req_valid  in  1  core issues a custom instruction
- core_req_ready  out  1  initiator idle and can accept a request
- core_funct7  in  7  instruction funct7
- core_funct3  in  3  instruction funct3
- core_rs1  in  32  operand A
- core_rs2  in  32  operand B
- core_rd_addr  in  5  destination register tag
- core_flush  in  1  kill the in-flight request
- core_rsp_valid  out  1  one-cycle result pulse; no back-pressure
- core_rsp_data  out  32  result
- core_rsp_rd_addr  out  5  tag echoed from the request
- core_rsp_error  out  1  completion caused by timeout
- busy  out  1  state != IDLE, or stale response pending
- cmd_valid  out  1  CFU command valid
- cmd_ready  in  1  CFU accepts command
- cmd_payload_function_id  out  10  {funct7, funct3}
- cmd_payload_inputs_0  out  32  rs1
- cmd_payload_inputs_1  out  32  rs2
- rsp_valid  in  1  CFU response valid
- rsp_ready  out  1  initiator accepts response
- rsp_payload_outputs_0  in  32  CFU result
- perf_ops  out  32  completed-operation count (optional feature)
- perf_stall  out  32  busy-cycle count (optional feature)

Behaviour:
- Reset value of every output is 0, except core_req_ready, which equals (state==IDLE && !stale) and is therefore 1 out of reset. State=IDLE, stale=0, killed=0, counter=0.
- FSM states: IDLE, CMD, WAIT, DONE.
- IDLE:
  - core_req_ready = !stale.
  - On core_req_valid && core_req_ready: register function_id, inputs, and rd; clear counter and killed; go to CMD.
- CMD:
  - cmd_valid = 1; payload stays stable until the handshake.
  - On cmd_valid && cmd_ready: go to WAIT.
- WAIT:
  - rsp_ready = 1.
  - On rsp_valid: capture rsp_payload_outputs_0, error=0, go to DONE.
- DONE (one cycle):
  - core_rsp_valid = !killed; data, rd, and error come from registers.
  - Next state is IDLE.
- Latency: with a zero-wait CFU (cmd_ready=1, rsp_valid the cycle after the cmd handshake), a request accepted in cycle 0 produces cmd_valid in cycle 1, rsp in cycle 2, and core_rsp_valid in cycle 3.
- Flush: core_flush in CMD or WAIT sets killed.
  - cmd_valid is never withdrawn because of a flush.
  - The response is still consumed; DONE suppresses core_rsp_valid.
  - Flush in IDLE or DONE has no effect.
- Timeout: the counter increments each cycle in CMD/WAIT.
  - When counter == TIMEOUT_CYCLES-1 and no handshake occurs that cycle, go to DONE with data=0 and error=1 (suppressed if killed).
  - Timeout from CMD drops cmd_valid; this is the only permitted withdrawal.
  - Timeout from WAIT sets stale.
- Stale: while stale, rsp_ready = 1 and core_req_ready = 0.
  - The next rsp_valid is discarded and clears stale.
- Simultaneous events:
  - Handshake beats timeout in the same cycle.
  - Flush and a handshake in the same cycle: both take effect (transition proceeds, killed is set).
  - A request is never accepted in the same cycle that stale clears.
- Reset mid-operation: returns to IDLE immediately; stale is cleared and any late CFU response is ignored.
- Outside WAIT/stale, rsp_ready = 0.

Optional Feature:
- Macro: CFU_PERF_CNT_EN.
- Defined:
  - perf_ops increments on every DONE cycle with core_rsp_valid=1.
  - perf_stall increments on every cycle busy=1.
  - Both counters wrap at 2^32 and are reset by reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Zero-wait CFU multiply-accumulate, funct7=0, funct3=1, rs1=0x01010101, rs2=0x02020202, rd=5 -> cmd_payload_function_id=0x001; core_rsp_valid in cycle 3 after acceptance; core_rsp_rd_addr=5; error=0; data equals the CFU output.
- cmd_ready held low for 10 cycles, then rsp delayed 4 cycles -> payload stable throughout; exactly one core_rsp_valid pulse; busy high continuously; core_req_ready=0 until IDLE.
- core_flush pulsed in WAIT -> CFU response consumed (rsp_ready=1 on that cycle); no core_rsp_valid; core_req_ready=1 the cycle after DONE.
- TIMEOUT_CYCLES=8, CFU never raises rsp_valid -> core_rsp_valid with error=1 and data=0 after 8 CMD/WAIT cycles; later rsp_valid with 0xABCD is discarded; new request accepted only after the stale response.
- Assert reset during WAIT -> all outputs 0 asynchronously; after release, core_req_ready=1 and a late rsp_valid is not captured.
- With CFU_PERF_CNT_EN defined, run 3 ops plus 1 flushed op -> perf_ops=3; perf_stall equals the total busy cycles.
